// File: rtl/clock_pkg.sv
// Shared constants for the digital clock: digit selector codes, BCD digit
// limits and the default 1 Hz prescaler divide ratio.
package clock_pkg;

   // Digit selector used by time setting (and the alarm block)
   typedef enum logic [2:0] {
      SEL_HOUR1 = 3'd2,
      SEL_HOUR0 = 3'd3,
      SEL_MIN1  = 3'd4,
      SEL_MIN0  = 3'd5
   } sel_e;

   localparam logic [3:0] BCD_LIM_9 = 4'd9;
   localparam logic [3:0] BCD_LIM_5 = 4'd5;
   localparam logic [3:0] BCD_LIM_2 = 4'd2;
   localparam logic [3:0] BCD_LIM_3 = 4'd3;

   localparam int TICK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/time_counter_bcd_digit.sv
// Single BCD digit register: increments when enabled, wraps to 0 at (or
// beyond) its limit and flags the wrap with a same-cycle carry pulse.
module bcd_digit
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       inc_i,
   input  logic       clr_i,
   input  logic [3:0] lim_i,
   output logic [3:0] q_o,
   output logic       carry_o
);

   logic [3:0] q_q, q_d;
   logic       wrap;

   // ">=" so a corrupted out-of-range digit returns to 0 on its next increment
   assign wrap    = (q_q >= lim_i);
   assign carry_o = en_i & inc_i & ~clr_i & wrap;
   assign q_o     = q_q;

   // Next digit value: clear wins over increment
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = 4'd0;
      end else if (en_i && inc_i) begin
         q_d = wrap ? 4'd0 : q_q + 4'd1;
      end
   end

   // Digit register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) q_q <= 4'd0;
      else     q_q <= q_d;
   end

endmodule

// File: rtl/time_counter.sv
// BCD time-of-day counter: prescaler to a 1 Hz tick, HH:MM:SS chain with
// single-cycle carry ripple, and digit-by-digit setting of hours/minutes.
//
// Selector state (timeSetSel)
//   state     | meaning
//   SEL_HOUR1 | add edits hour tens (0..2), hour0 clamped to 3 on step to 2
//   SEL_HOUR0 | add edits hour units (limit 3 when hour1=2, else 9)
//   SEL_MIN1  | add edits minute tens (0..5)
//   SEL_MIN0  | add edits minute units (0..9)
module time_counter
   import clock_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       timeSetMod,
   input  logic       selPress,
   input  logic       addPress,
   output logic [3:0] hour1,
   output logic [3:0] hour0,
   output logic [3:0] minute1,
   output logic [3:0] minute0,
   output logic [3:0] second1,
   output logic [3:0] second0,
   output logic [2:0] timeSetSel,
   output logic       secTick
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic          run_tick;
   logic          tick_q;
   sel_e          sel_q, sel_d;
   logic [3:0]    h1_q, h1_d, h0_q, h0_d, h0_lim;
   logic          s0_c, s1_c, m0_c, m1_c;
   logic          add_m0, add_m1;

   assign run_tick = !timeSetMod && (presc_q == PW'(TICK_DIV - 1));
   assign add_m0   = addPress && (sel_q == SEL_MIN0);
   assign add_m1   = addPress && (sel_q == SEL_MIN1);

   // Prescaler: free-runs in run mode, parked at 0 in set mode
   always_comb begin
      presc_d = presc_q + PW'(1);
      if (timeSetMod || run_tick) presc_d = '0;
   end

   // Selector steps only in set mode; any illegal code recovers to hour1
   always_comb begin
      sel_d = sel_q;
      if (timeSetMod && selPress) begin
         case (sel_q)
            SEL_HOUR1: sel_d = SEL_HOUR0;
            SEL_HOUR0: sel_d = SEL_MIN1;
            SEL_MIN1:  sel_d = SEL_MIN0;
            default:   sel_d = SEL_HOUR1;
         endcase
      end
   end

   // Hour digits: run-mode rollover at 23, set-mode edits without carry
   always_comb begin
      h1_d   = h1_q;
      h0_d   = h0_q;
      h0_lim = (h1_q >= BCD_LIM_2) ? BCD_LIM_3 : BCD_LIM_9;
      if (timeSetMod) begin
         if (addPress && sel_q == SEL_HOUR1) begin
            h1_d = (h1_q >= BCD_LIM_2) ? 4'd0 : h1_q + 4'd1;
            if (h1_d == BCD_LIM_2 && h0_q > BCD_LIM_3) h0_d = BCD_LIM_3;
         end else if (addPress && sel_q == SEL_HOUR0) begin
            h0_d = (h0_q >= h0_lim) ? 4'd0 : h0_q + 4'd1;
         end
      end else if (m1_c) begin
         if (h0_q >= h0_lim) begin
            h0_d = 4'd0;
            h1_d = (h1_q >= BCD_LIM_2) ? 4'd0 : h1_q + 4'd1;
         end else begin
            h0_d = h0_q + 4'd1;
         end
      end
   end

   // Prescaler, selector, hours and tick registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         sel_q   <= SEL_HOUR1;
         h1_q    <= 4'd0;
         h0_q    <= 4'd0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sel_q   <= sel_d;
         h1_q    <= h1_d;
         h0_q    <= h0_d;
         tick_q  <= run_tick;
      end
   end

   bcd_digit u_sec0 (
      .clk(clk), .rst(rst), .en_i(run_tick), .inc_i(1'b1), .clr_i(timeSetMod),
      .lim_i(BCD_LIM_9), .q_o(second0), .carry_o(s0_c)
   );

   bcd_digit u_sec1 (
      .clk(clk), .rst(rst), .en_i(1'b1), .inc_i(s0_c), .clr_i(timeSetMod),
      .lim_i(BCD_LIM_5), .q_o(second1), .carry_o(s1_c)
   );

   bcd_digit u_min0 (
      .clk(clk), .rst(rst), .en_i(1'b1), .inc_i(timeSetMod ? add_m0 : s1_c), .clr_i(1'b0),
      .lim_i(BCD_LIM_9), .q_o(minute0), .carry_o(m0_c)
   );

   bcd_digit u_min1 (
      .clk(clk), .rst(rst), .en_i(1'b1), .inc_i(timeSetMod ? add_m1 : m0_c), .clr_i(1'b0),
      .lim_i(BCD_LIM_5), .q_o(minute1), .carry_o(m1_c)
   );

   assign hour1      = h1_q;
   assign hour0      = h0_q;
   assign timeSetSel = sel_q;
   assign secTick    = tick_q;

endmodule
